fetch_unit: RTL and testbench

In-order instruction fetch stage feeding the `cpu` decode path. Owns the architectural fetch PC, issues word-aligned requests to instruction memory over a valid/ready channel, and buffers in-order responses with their PCs. Delivers `{pc, instr}` pairs downstream over a valid/ready handshake. Handles branch redirects by flushing buffered entries and discarding stale in-flight responses, and supports a halt request that quiesces fetching.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// In-order instruction fetch: owns the fetch PC, issues word requests to imem,
// buffers in-order responses with their PCs and hands {pc, instr} downstream.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_pc,
  output logic [31:0] inst_data,
  output logic [63:0] pc,
  output logic        fetch_idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [63:0]      pc_q;
  logic [63:0]      bpc   [DEPTH];
  logic [31:0]      bdata [DEPTH];
  logic [DEPTH-1:0] bfilled;
  ptr_t             alloc, fill, head;
  cnt_t             count, pend, drop_cnt;

  logic acc, take, discard, pop;
  cnt_t redir_drop;

  assign pc             = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = !reset && !halt_req && (count != FULL) && (drop_cnt == '0);
  assign inst_valid     = !reset && (count != '0) && bfilled[head];
  assign inst_pc        = inst_valid ? bpc[head] : '0;
  assign inst_data      = inst_valid ? bdata[head] : '0;
  assign fetch_idle     = halt_req && (reset || ((count == '0) && (drop_cnt == '0)));

  always_comb begin
    acc     = imem_req_valid && imem_req_ready;
    discard = imem_resp_valid && (drop_cnt != '0);
    take    = imem_resp_valid && (drop_cnt == '0) && (pend != '0);
    pop     = inst_valid && inst_ready;
    // Every word still owed by memory becomes stale; a response that is
    // neither dropped nor filled (protocol error) is not subtracted.
    redir_drop = pend + drop_cnt + cnt_t'(acc) - cnt_t'(discard || take);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC & ~64'h3;
      bfilled  <= '0;
      alloc    <= '0;
      fill     <= '0;
      head     <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bpc[i]   <= '0;
        bdata[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc & ~64'h3;
      bfilled  <= '0;
      alloc    <= '0;
      fill     <= '0;
      head     <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= redir_drop;
    end else begin
      if (pop) begin
        bfilled[head] <= 1'b0;
        head          <= head + ptr_t'(1);
      end
      if (acc) begin
        bpc[alloc]     <= pc_q;
        bfilled[alloc] <= 1'b0;
        alloc          <= alloc + ptr_t'(1);
        pc_q           <= pc_q + 64'd4;
      end
      if (take) begin
        bdata[fill]   <= imem_resp_data;
        bfilled[fill] <= 1'b1;
        fill          <= fill + ptr_t'(1);
      end
      if (discard) drop_cnt <= drop_cnt - cnt_t'(1);
      count <= count + cnt_t'(acc) - cnt_t'(pop);
      pend  <= pend + cnt_t'(acc) - cnt_t'(take);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based model of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        inst_valid, inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst_data;
  logic [63:0] pc;
  logic        fetch_idle;

  logic        w_req_valid, w_inst_valid, w_idle;
  logic [63:0] w_addr, w_inst_pc, w_pc;
  logic [31:0] w_inst_data;
  logic        w_ready = 1'b1, w_zero = 1'b0;
  logic [31:0] w_data = '0;
  logic [63:0] w_rpc = '0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data), .pc(pc), .fetch_idle(fetch_idle)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(DEPTH)) dutw (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready),
    .imem_req_addr(w_addr), .imem_resp_valid(w_zero),
    .imem_resp_data(w_data), .redirect_valid(w_zero),
    .redirect_pc(w_rpc), .halt_req(w_zero),
    .inst_valid(w_inst_valid), .inst_ready(w_zero),
    .inst_pc(w_inst_pc), .inst_data(w_inst_data), .pc(w_pc), .fetch_idle(w_idle)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory queue tagged with fetch epoch; the output queue
  // holds current-epoch fetches in order, marked once their word returns.
  typedef struct { logic [63:0] addr; int unsigned ep; int unsigned due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] data; bit got; } ent_t;

  mreq_t       memq[$];
  ent_t        obuf[$];
  logic [63:0] mpc;
  int unsigned ep, cyc;

  bit          drv_ready, drv_iready, drv_halt, drv_redir;
  logic [63:0] drv_rpc;
  int unsigned lat;
  int          acc_cnt;
  bit          got_acc, got_pop;
  logic [63:0] first_acc, first_pop;

  task automatic do_reset(input bit h);
    @(negedge clk);
    reset = 1'b1; halt_req = h; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_pc", pc, 0);
    chk("rst_fetch_idle", fetch_idle, h);
    chk("rst_wrap_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    memq.delete(); obuf.delete();
    mpc = '0; ep = 0;
    drv_ready = 1; drv_iready = 1; drv_halt = 0; drv_redir = 0; drv_rpc = '0; lat = 1;
    @(posedge clk);
    #1 reset = 1'b0; halt_req = 1'b0;
  endtask

  task automatic step();
    int  stale, idx;
    bit  e_req, e_iv, acc, rsp, pop;
    @(negedge clk);
    imem_req_ready = drv_ready; inst_ready = drv_iready; halt_req = drv_halt;
    redirect_valid = drv_redir; redirect_pc = drv_rpc;
    rsp = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? memq[0].addr[33:2] : $urandom();
    #1;
    stale = 0;
    foreach (memq[k]) if (memq[k].ep != ep) stale++;
    e_req = !drv_halt && (obuf.size() < DEPTH) && (stale == 0);
    e_iv  = (obuf.size() > 0) && obuf[0].got;
    chk("req_valid", imem_req_valid, e_req);
    chk("req_addr", imem_req_addr, mpc);
    chk("pc", pc, mpc);
    chk("inst_valid", inst_valid, e_iv);
    if (e_iv) begin
      chk("inst_pc", inst_pc, obuf[0].pc);
      chk("inst_data", inst_data, obuf[0].data);
    end
    chk("fetch_idle", fetch_idle, drv_halt && (obuf.size() == 0) && (stale == 0));
    acc = e_req && drv_ready;
    pop = e_iv && drv_iready;
    if (acc) begin
      acc_cnt++;
      if (!got_acc) begin got_acc = 1; first_acc = mpc; end
    end
    if (pop && !got_pop) begin got_pop = 1; first_pop = obuf[0].pc; end
    @(posedge clk);
    if (rsp) begin
      mreq_t r;
      r = memq[0];
      memq.delete(0);
      if (r.ep == ep) begin
        idx = -1;
        foreach (obuf[k]) if (idx < 0 && !obuf[k].got) idx = k;
        chk("resp_has_slot", 64'(idx >= 0), 1);
        if (idx >= 0) begin obuf[idx].data = r.addr[33:2]; obuf[idx].got = 1; end
      end
    end
    if (acc) memq.push_back('{mpc, ep, cyc + ((lat == 0) ? $urandom_range(1, 4) : lat)});
    if (drv_redir) begin
      ep++;
      obuf.delete();
      mpc = drv_rpc & ~64'h3;
    end else begin
      if (pop) obuf.delete(0);
      if (acc) begin
        obuf.push_back('{mpc, 32'h0, 1'b0});
        mpc = mpc + 64'd4;
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [63:0] e_ipc;
    logic [31:0] e_idata;
  } vec_t;

  vec_t vt[6];
  int   n;

  initial begin
    cyc = 0;
    vt[0] = '{1'b0, 32'd0, 1'b1, 64'h00, 1'b0, 64'h0, 32'd0};
    vt[1] = '{1'b1, 32'd0, 1'b1, 64'h04, 1'b0, 64'h0, 32'd0};
    vt[2] = '{1'b1, 32'd1, 1'b1, 64'h08, 1'b1, 64'h0, 32'd0};
    vt[3] = '{1'b1, 32'd2, 1'b1, 64'h0C, 1'b1, 64'h4, 32'd1};
    vt[4] = '{1'b1, 32'd3, 1'b1, 64'h10, 1'b1, 64'h8, 32'd2};
    vt[5] = '{1'b1, 32'd4, 1'b1, 64'h14, 1'b1, 64'hC, 32'd3};

    // Streaming from reset with a 1-cycle memory returning addr>>2.
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_req_ready = 1'b1; inst_ready = 1'b1; halt_req = 1'b0; redirect_valid = 1'b0;
      imem_resp_valid = vt[i].rv; imem_resp_data = vt[i].rd;
      #1;
      chk("vec_req_valid", imem_req_valid, vt[i].e_req);
      chk("vec_req_addr", imem_req_addr, vt[i].e_addr);
      chk("vec_inst_valid", inst_valid, vt[i].e_iv);
      if (vt[i].e_iv) begin
        chk("vec_inst_pc", inst_pc, vt[i].e_ipc);
        chk("vec_inst_data", inst_data, vt[i].e_idata);
      end
      if (i == 0) begin
        chk("wrap_first_valid", w_req_valid, 1);
        chk("wrap_first_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      end
      if (i == 1) chk("wrap_second_addr", w_addr, 64'h0);
    end

    // Consumer stalled: buffer fills to DEPTH, then drains in order.
    do_reset(0);
    drv_iready = 0; acc_cnt = 0;
    repeat (10) step();
    #1;
    chk("stall_accepts", acc_cnt, DEPTH);
    chk("stall_req_valid", imem_req_valid, 0);
    drv_iready = 1; got_acc = 0; got_pop = 0; first_acc = '1; first_pop = '1;
    repeat (10) step();
    chk("stall_first_pop", first_pop, 64'h0);
    chk("stall_resume_addr", first_acc, 64'h10);

    // Latency 3, two in flight, redirect to an unaligned target.
    do_reset(0);
    lat = 3;
    repeat (2) step();
    drv_ready = 0; drv_redir = 1; drv_rpc = 64'h1003;
    step();
    drv_ready = 1; drv_redir = 0; got_acc = 0; got_pop = 0; first_acc = '1; first_pop = '1;
    n = 0;
    while (!got_acc && n < 20) begin step(); n++; end
    chk("redir_wait", n, 3);
    chk("redir_addr", first_acc, 64'h1000);
    while (!got_pop && n < 40) begin step(); n++; end
    chk("redir_first_inst", first_pop, 64'h1000);

    // Redirect coinciding with a request accept and a response.
    do_reset(0);
    lat = 2;
    repeat (5) step();
    drv_redir = 1; drv_rpc = 64'h2000;
    step();
    drv_redir = 0; got_acc = 0; first_acc = '1;
    n = 0;
    while (!got_acc && n < 20) begin step(); n++; end
    chk("same_cycle_wait", n, 3);
    chk("same_cycle_addr", first_acc, 64'h2000);
    repeat (10) step();

    // Halt with two in flight: both delivered, then idle; resume at pc.
    do_reset(1);
    lat = 3;
    repeat (2) step();
    drv_halt = 1; acc_cnt = 0;
    repeat (8) step();
    #1;
    chk("halt_accepts", acc_cnt, 0);
    chk("halt_idle", fetch_idle, 1);
    drv_halt = 0; got_acc = 0; first_acc = '1;
    step();
    chk("halt_resume_addr", first_acc, 64'h8);

    // Randomized traffic, including one reset mid-operation.
    do_reset(0);
    lat = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin do_reset(0); lat = 0; end
      drv_ready  = ($urandom_range(0, 3) != 0);
      drv_iready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) drv_halt = !drv_halt;
      drv_redir = ($urandom_range(0, 24) == 0);
      drv_rpc   = {$urandom(), $urandom()};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
